// File: rtl/vx_vec_scoreboard_pkg.sv
// Shared issue-stage types: scoreboard payload, register index widths
// and the register bank layout (int 0-31, fp 32-63, vector 64-95).
package VX_gpu_pkg;

    localparam int NUM_WARPS    = 4;
    localparam int NUM_REGS     = 96;
    localparam int MAX_GROUP    = 8;
    localparam int NUM_THREADS  = 4;

    localparam int WIS_W   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int NR_BITS = $clog2(NUM_REGS);

    localparam int REG_INT_BASE = 0;
    localparam int REG_FP_BASE  = 32;
    localparam int REG_VEC_BASE = 64;

    typedef struct packed {
        logic [31:0]          uuid;
        logic [WIS_W-1:0]     wis;
        logic [NUM_THREADS-1:0] tmask;
        logic [31:0]          PC;
        logic [2:0]           ex_type;
        logic [3:0]           op_type;
        logic [7:0]           op_args;
        logic                 wb;
        logic [NR_BITS-1:0]   rd;
        logic [NR_BITS-1:0]   rs1;
        logic [NR_BITS-1:0]   rs2;
        logic [NR_BITS-1:0]   rs3;
        logic [NR_BITS-1:0]   vd;
        logic [NR_BITS-1:0]   vd_n;
        logic [NR_BITS-1:0]   vs1_n;
        logic [NR_BITS-1:0]   vs2_n;
    } sb_data_t;

    localparam int SB_DATAW = $bits(sb_data_t);

    // A non-zero vd_n marks a vector op whose destination is the vd group.
    function automatic logic is_vector_dest(input logic [NR_BITS-1:0] vd_n);
        return (vd_n != '0);
    endfunction

endpackage

// File: rtl/vx_vec_scoreboard_if.sv
// Valid/ready payload channel used both from the instruction buffer and
// towards the operand collector.
interface vx_vec_scoreboard_if;
    import VX_gpu_pkg::*;

    logic     valid;
    sb_data_t data;
    logic     ready;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);

endinterface

// File: rtl/vx_reg_group_mask.sv
// Expands a register group (base, count) into a one-hot-per-register mask.
// Count 0 means one register, counts above MAX_GROUP are clamped, and
// indices past the end of the register file are dropped (no wrap).
module vx_reg_group_mask #(
    parameter int NUM_REGS  = 96,
    parameter int MAX_GROUP = 8,
    parameter int NR_BITS   = 7
) (
    input  logic [NR_BITS-1:0]  base,
    input  logic [NR_BITS-1:0]  n,
    output logic [NUM_REGS-1:0] mask
);

    int unsigned cnt;

    // Clamp the count, then select every register in [base, base+cnt).
    always_comb begin
        if (n == '0) begin
            cnt = 1;
        end else if (32'(n) > MAX_GROUP) begin
            cnt = MAX_GROUP;
        end else begin
            cnt = 32'(n);
        end
        mask = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            mask[i] = (i >= 32'(base)) && (i < 32'(base) + cnt);
        end
    end

endmodule

// File: rtl/vx_vec_scoreboard.sv
// Issue-stage scoreboard: stages one instruction, holds it while any of its
// source or destination registers has a write pending in its warp, then
// forwards it unchanged. Pending bits are set on issue and cleared by
// writeback releases.
module vx_vec_scoreboard
    import VX_gpu_pkg::*;
#(
    parameter int NUM_WARPS = VX_gpu_pkg::NUM_WARPS,
    parameter int NUM_REGS  = VX_gpu_pkg::NUM_REGS,
    parameter int MAX_GROUP = VX_gpu_pkg::MAX_GROUP
) (
    input  logic                clk,
    input  logic                reset_n,
    vx_vec_scoreboard_if.slave  in_if,
    vx_vec_scoreboard_if.master out_if,
    input  logic                wb_valid,
    input  logic [WIS_W-1:0]    wb_wis,
    input  logic [NR_BITS-1:0]  wb_rd,
    input  logic [NR_BITS-1:0]  wb_rd_n,
    output logic [31:0]         perf_stalls
);

    // x0 is hardwired and never participates in hazards.
    localparam logic [NUM_REGS-1:0] NOT_X0 = ~NUM_REGS'(1);

    logic                stage_valid;
    sb_data_t            stage_data;
    logic [NUM_REGS-1:0] pend [NUM_WARPS];

    logic [NUM_REGS-1:0] rs1_mask, rs2_mask, rs3_mask, dst_raw, rel_mask;
    logic [NUM_REGS-1:0] src_mask, dst_mask, pend_cur;
    logic [NR_BITS-1:0]  dst_base, dst_n;
    logic                hazard, out_fire;

    assign dst_base = is_vector_dest(stage_data.vd_n) ? stage_data.vd   : stage_data.rd;
    assign dst_n    = is_vector_dest(stage_data.vd_n) ? stage_data.vd_n : NR_BITS'(1);

    vx_reg_group_mask #(.NUM_REGS(NUM_REGS), .MAX_GROUP(MAX_GROUP), .NR_BITS(NR_BITS))
        u_rs1 (.base(stage_data.rs1), .n(stage_data.vs1_n), .mask(rs1_mask));
    vx_reg_group_mask #(.NUM_REGS(NUM_REGS), .MAX_GROUP(MAX_GROUP), .NR_BITS(NR_BITS))
        u_rs2 (.base(stage_data.rs2), .n(stage_data.vs2_n), .mask(rs2_mask));
    vx_reg_group_mask #(.NUM_REGS(NUM_REGS), .MAX_GROUP(MAX_GROUP), .NR_BITS(NR_BITS))
        u_rs3 (.base(stage_data.rs3), .n(NR_BITS'(1)), .mask(rs3_mask));
    vx_reg_group_mask #(.NUM_REGS(NUM_REGS), .MAX_GROUP(MAX_GROUP), .NR_BITS(NR_BITS))
        u_dst (.base(dst_base), .n(dst_n), .mask(dst_raw));
    vx_reg_group_mask #(.NUM_REGS(NUM_REGS), .MAX_GROUP(MAX_GROUP), .NR_BITS(NR_BITS))
        u_rel (.base(wb_rd), .n(wb_rd_n), .mask(rel_mask));

    assign src_mask = (rs1_mask | rs2_mask | rs3_mask) & NOT_X0;
    assign dst_mask = stage_data.wb ? (dst_raw & NOT_X0) : '0;

    // Select the pending row of the staged instruction's warp.
    always_comb begin
        pend_cur = '0;
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            if (stage_data.wis == WIS_W'(w)) begin
                pend_cur = pend[w];
            end
        end
    end

    assign hazard       = stage_valid && (|((src_mask | dst_mask) & pend_cur));
    assign out_if.valid = stage_valid && !hazard;
    assign out_if.data  = stage_data;
    assign out_fire     = out_if.valid && out_if.ready;
    assign in_if.ready  = !stage_valid || out_fire;

    // Staging register: load on accept, empty on fire without refill.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_valid <= 1'b0;
            stage_data  <= '0;
        end else if (in_if.valid && in_if.ready) begin
            stage_valid <= 1'b1;
            stage_data  <= in_if.data;
        end else if (out_fire) begin
            stage_valid <= 1'b0;
        end
    end

    // Pending table: clear releases, then set issued destinations (set wins).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                pend[w] <= '0;
            end
        end else begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                pend[w] <= (pend[w] & ~((wb_valid && wb_wis == WIS_W'(w)) ? rel_mask : '0))
                         | ((out_fire && stage_data.wis == WIS_W'(w)) ? dst_mask : '0);
            end
        end
    end

    // Saturating count of cycles spent holding a hazarded instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stalls <= '0;
        end else if (hazard && perf_stalls != '1) begin
            perf_stalls <= perf_stalls + 32'd1;
        end
    end

endmodule
